// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU control unit: ALU opcodes, instruction fields,
// branch condition codes, PSR flag positions, FSM states and the instruction decoder.
package cpu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_CMP  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_NOT  = 4'd6;
   localparam logic [3:0] ALU_LSH  = 4'd7;
   localparam logic [3:0] ALU_RSH  = 4'd8;
   localparam logic [3:0] ALU_ARSH = 4'd9;
   localparam logic [3:0] ALU_MUL  = 4'd10;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_MEMJ  = 4'h4;
   localparam logic [3:0] OP_ADDUI = 4'h6;
   localparam logic [3:0] OP_SHIFT = 4'h8;
   localparam logic [3:0] OP_BCOND = 4'hC;

   // ext field values; I-type arithmetic reuses these as the primary opcode
   localparam logic [3:0] EXT_NOP   = 4'h0;
   localparam logic [3:0] EXT_AND   = 4'h1;
   localparam logic [3:0] EXT_OR    = 4'h2;
   localparam logic [3:0] EXT_XOR   = 4'h3;
   localparam logic [3:0] EXT_ADD   = 4'h5;
   localparam logic [3:0] EXT_ADDU  = 4'h6;
   localparam logic [3:0] EXT_ADDC  = 4'h7;
   localparam logic [3:0] EXT_SUB   = 4'h9;
   localparam logic [3:0] EXT_SUBC  = 4'hA;
   localparam logic [3:0] EXT_CMP   = 4'hB;
   localparam logic [3:0] EXT_MUL   = 4'hE;
   localparam logic [3:0] EXT_LOAD  = 4'h0;
   localparam logic [3:0] EXT_STOR  = 4'h4;
   localparam logic [3:0] EXT_JCOND = 4'hC;
   localparam logic [3:0] EXT_LSH   = 4'h4;
   localparam logic [3:0] EXT_LSHI  = 4'h0;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_HI = 4'h4;
   localparam logic [3:0] COND_LS = 4'h5;
   localparam logic [3:0] COND_GT = 4'h6;
   localparam logic [3:0] COND_LE = 4'h7;
   localparam logic [3:0] COND_FS = 4'h8;
   localparam logic [3:0] COND_FC = 4'h9;
   localparam logic [3:0] COND_LO = 4'hA;
   localparam logic [3:0] COND_HS = 4'hB;
   localparam logic [3:0] COND_LT = 4'hC;
   localparam logic [3:0] COND_GE = 4'hD;
   localparam logic [3:0] COND_UC = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int FLAG_N = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_L = 3;
   localparam int FLAG_C = 4;

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_MEM_WAIT, ST_BRANCH, ST_HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_ILLEGAL, CLS_NOP, CLS_ALU, CLS_LOAD, CLS_STOR, CLS_BRANCH
   } cls_t;

   typedef struct packed {
      cls_t       cls;
      logic [3:0] alu_op;
      logic       imm_sel;
      logic       sext;
      logic       flags_en;
      logic       reg_en;
   } dec_t;

   function automatic dec_t decode(input logic [15:0] ir);
      dec_t       d;
      logic [3:0] op;
      logic [3:0] ext;
      logic [3:0] code;
      logic       known;
      op         = ir[15:12];
      ext        = ir[7:4];
      code       = (op == OP_RTYPE) ? ext : op;
      d.cls      = CLS_ILLEGAL;
      d.alu_op   = ALU_ADD;
      d.imm_sel  = 1'b0;
      d.sext     = 1'b0;
      d.flags_en = 1'b0;
      d.reg_en   = 1'b1;
      known      = 1'b1;
      case (code)
         EXT_ADD, EXT_ADDU, EXT_ADDC: begin d.alu_op = ALU_ADD; d.flags_en = 1'b1; end
         EXT_SUB, EXT_SUBC:           begin d.alu_op = ALU_SUB; d.flags_en = 1'b1; end
         EXT_CMP: begin d.alu_op = ALU_CMP; d.flags_en = 1'b1; d.reg_en = 1'b0; end
         EXT_MUL: d.alu_op = ALU_MUL;
         EXT_AND: d.alu_op = ALU_AND;
         EXT_OR:  d.alu_op = ALU_OR;
         EXT_XOR: d.alu_op = ALU_XOR;
         default: known = 1'b0;
      endcase
      if (op == OP_RTYPE && ext == EXT_NOP) begin
         d.cls = CLS_NOP;
      end else if (op == OP_MEMJ) begin
         case (ext)
            EXT_LOAD:  d.cls = CLS_LOAD;
            EXT_STOR:  d.cls = CLS_STOR;
            EXT_JCOND: d.cls = CLS_BRANCH;
            default:   d.cls = CLS_ILLEGAL;
         endcase
      end else if (op == OP_SHIFT) begin
         if (ext == EXT_LSH || ext == EXT_LSHI) begin
            d.cls     = CLS_ALU;
            d.alu_op  = ALU_LSH;
            d.imm_sel = (ext == EXT_LSHI);
            d.sext    = (ext == EXT_LSHI);
         end
      end else if (op == OP_BCOND) begin
         d.cls = CLS_BRANCH;
      end else if (known) begin
         d.cls     = CLS_ALU;
         d.imm_sel = (op != OP_RTYPE);
         d.sext    = (op != OP_RTYPE) && (op != OP_ADDUI);
      end
      return d;
   endfunction

endpackage

// File: rtl/cpu_cond_eval.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and the latched
// PSR flags {C,L,F,Z,N} to a take/not-take decision.
module cpu_cond_eval
   import cpu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [4:0] flags,
   output logic       take
);

   logic c, l, f, z, n;

   assign c = flags[FLAG_C];
   assign l = flags[FLAG_L];
   assign f = flags[FLAG_F];
   assign z = flags[FLAG_Z];
   assign n = flags[FLAG_N];

   always_comb begin
      take = 1'b0;
      case (cond)
         COND_EQ: take = z;
         COND_NE: take = !z;
         COND_CS: take = c;
         COND_CC: take = !c;
         COND_HI: take = l;
         COND_LS: take = !l;
         COND_GT: take = n;
         COND_LE: take = !n;
         COND_FS: take = f;
         COND_FC: take = !f;
         COND_LO: take = !l && !z;
         COND_HS: take = l || z;
         COND_LT: take = !n && !z;
         COND_GE: take = n || z;
         COND_UC: take = 1'b1;
         default: take = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit: fetch/decode/execute FSM with LOAD/STOR handshake and
// timeout, flag-conditioned branches, and a sticky Fault flag.
module cpu_ctrl_fsm
   import cpu_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int REG_AW  = 4,
   parameter int IMM_W   = 8,
   parameter int MEM_TMO = 15
)(
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic [INSTR_W-1:0] Instr,
   input  logic [4:0]         ALUFlags,
   input  logic               MemReady,
   output logic               PCEn,
   output logic               PCLoad,
   output logic               RegEn,
   output logic               FlagsEn,
   output logic               MemReq,
   output logic               MemWe,
   output logic               Imm_s,
   output logic               Signed,
   output logic               MemToReg,
   output logic [3:0]         ALUOpCode,
   output logic [REG_AW-1:0]  RdestRegLoc,
   output logic [REG_AW-1:0]  RsrcRegLoc,
   output logic [IMM_W-1:0]   Imm,
   output logic               Fault
);

   localparam int              CNT_W    = $clog2(MEM_TMO + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TMO - 1);

   state_t             state_reg, state_next;
   logic [INSTR_W-1:0] ir_reg, ir_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               fault_reg, fault_next;
   logic [4:0]         psr_reg;
   dec_t               dec;
   logic               take;
   logic               is_load;

   assign dec     = decode(ir_reg[15:0]);
   assign is_load = (dec.cls == CLS_LOAD);

   cpu_cond_eval u_cond_eval (
      .cond  (ir_reg[11:8]),
      .flags (psr_reg),
      .take  (take)
   );

   // Shadow of the datapath PSR so branches see the flags of earlier instructions
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg <= ST_FETCH;
         ir_reg    <= '0;
         cnt_reg   <= '0;
         fault_reg <= 1'b0;
         psr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ir_reg    <= ir_next;
         cnt_reg   <= cnt_next;
         fault_reg <= fault_next;
         if (FlagsEn) psr_reg <= ALUFlags;
      end
   end

   always_comb begin
      state_next = state_reg;
      ir_next    = ir_reg;
      cnt_next   = cnt_reg;
      fault_next = fault_reg;
      PCEn       = 1'b0;
      PCLoad     = 1'b0;
      RegEn      = 1'b0;
      FlagsEn    = 1'b0;
      MemReq     = 1'b0;
      MemWe      = 1'b0;
      Imm_s      = 1'b0;
      Signed     = 1'b0;
      MemToReg   = 1'b0;
      case (state_reg)
         ST_FETCH: begin
            // Reset parks the FSM in FETCH; keep the PC still until reset releases
            PCEn       = Rst_n;
            ir_next    = Instr;
            state_next = ST_DECODE;
         end
         ST_DECODE: begin
            case (dec.cls)
               CLS_NOP:            state_next = ST_FETCH;
               CLS_ALU:            state_next = ST_EXEC;
               CLS_LOAD, CLS_STOR: state_next = ST_MEM;
               CLS_BRANCH:         state_next = ST_BRANCH;
               default: begin
                  fault_next = 1'b1;
                  state_next = ST_HALT;
               end
            endcase
         end
         ST_EXEC: begin
            RegEn      = dec.reg_en;
            FlagsEn    = dec.flags_en;
            Imm_s      = dec.imm_sel;
            Signed     = dec.sext;
            state_next = ST_FETCH;
         end
         ST_MEM: begin
            MemReq     = 1'b1;
            MemWe      = !is_load;
            cnt_next   = '0;
            state_next = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            MemReq = 1'b1;
            MemWe  = !is_load;
            if (MemReady) begin
               RegEn      = is_load;
               MemToReg   = is_load;
               cnt_next   = '0;
               state_next = ST_FETCH;
            end else if (cnt_reg == CNT_LAST) begin
               fault_next = 1'b1;
               state_next = ST_HALT;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_BRANCH: begin
            PCLoad     = take;
            state_next = ST_FETCH;
         end
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_FETCH;
      endcase
   end

   assign ALUOpCode   = dec.alu_op;
   assign RdestRegLoc = REG_AW'(ir_reg[11:8]);
   assign RsrcRegLoc  = REG_AW'(ir_reg[3:0]);
   assign Imm         = IMM_W'(ir_reg[7:0]);
   assign Fault       = fault_reg;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: each driven cycle queues the expected output
// vector, which a negedge monitor pops and compares against the DUT.
module tb_cpu_ctrl_fsm;

   localparam int          MEM_TMO = 15;
   localparam logic [15:0] ILL     = 16'hD000;

   logic        Clk      = 1'b0;
   logic        Rst_n    = 1'b1;
   logic [15:0] Instr    = 16'h0000;
   logic [4:0]  ALUFlags = 5'h00;
   logic        MemReady = 1'b0;
   logic        PCEn, PCLoad, RegEn, FlagsEn, MemReq, MemWe, Imm_s, Signed, MemToReg, Fault;
   logic [3:0]  ALUOpCode, RdestRegLoc, RsrcRegLoc;
   logic [7:0]  Imm;

   cpu_ctrl_fsm #(.INSTR_W(16), .REG_AW(4), .IMM_W(8), .MEM_TMO(MEM_TMO)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
      .PCEn(PCEn), .PCLoad(PCLoad), .RegEn(RegEn), .FlagsEn(FlagsEn), .MemReq(MemReq),
      .MemWe(MemWe), .Imm_s(Imm_s), .Signed(Signed), .MemToReg(MemToReg),
      .ALUOpCode(ALUOpCode), .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc),
      .Imm(Imm), .Fault(Fault)
   );

   always #5 Clk = ~Clk;

   logic [29:0] obs;
   assign obs = {PCEn, PCLoad, RegEn, FlagsEn, MemReq, MemWe, Imm_s, Signed, MemToReg,
                 ALUOpCode, RdestRegLoc, RsrcRegLoc, Imm, Fault};

   logic [29:0] exp_q[$];
   string       tag_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] prev_ir  = 16'h0000;
   logic [3:0]  prev_alu = 4'd0;
   logic [4:0]  psr      = 5'h00;
   logic        fault_m  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   always @(negedge Clk) begin
      if (exp_q.size() > 0) check(tag_q.pop_front(), {2'b00, obs}, {2'b00, exp_q.pop_front()});
   end

   function automatic logic [29:0] mk(input logic pcen, pcload, regen, flagsen, memreq, memwe,
                                      imms, sgn, m2r, input logic [3:0] alu,
                                      input logic [15:0] ir, input logic flt);
      return {pcen, pcload, regen, flagsen, memreq, memwe, imms, sgn, m2r,
              alu, ir[11:8], ir[3:0], ir[7:0], flt};
   endfunction

   // Called at posedge+2: drive this cycle's inputs, queue its expectation, move to next cycle
   task automatic cyc(input string tag, input logic [15:0] ins, input logic rdy,
                      input logic [4:0] flg, input logic [29:0] ev);
      Instr    = ins;
      MemReady = rdy;
      ALUFlags = flg;
      exp_q.push_back(ev);
      tag_q.push_back(tag);
      @(posedge Clk);
      #2;
   endtask

   task automatic fetch_dec(input string nm, input logic [15:0] ins, input logic [3:0] alu);
      cyc({nm, ".F"}, ins, 1'b0, ~psr, mk(1,0,0,0,0,0,0,0,0, prev_alu, prev_ir, fault_m));
      prev_ir  = ins;
      prev_alu = alu;
      cyc({nm, ".D"}, ILL, 1'b0, ~psr, mk(0,0,0,0,0,0,0,0,0, alu, ins, fault_m));
   endtask

   task automatic run_alu(input string nm, input logic [15:0] ins, input logic [3:0] alu,
                          input logic regen, flagsen, imms, sgn, input logic [4:0] flg);
      $display("txn %s instr=%h", nm, ins);
      fetch_dec(nm, ins, alu);
      cyc({nm, ".E"}, ILL, 1'b0, flg, mk(0,0,regen,flagsen,0,0,imms,sgn,0, alu, ins, 1'b0));
      if (flagsen) psr = flg;
   endtask

   task automatic run_br(input string nm, input logic [15:0] ins, input logic take);
      $display("txn %s instr=%h take=%0d", nm, ins, take);
      fetch_dec(nm, ins, 4'd0);
      cyc({nm, ".B"}, ILL, 1'b0, ~psr, mk(0,take,0,0,0,0,0,0,0, 4'd0, ins, 1'b0));
   endtask

   task automatic run_mem(input string nm, input logic [15:0] ins, input logic ld,
                          input int wait_n, input logic early_rdy);
      $display("txn %s instr=%h waits=%0d", nm, ins, wait_n);
      fetch_dec(nm, ins, 4'd0);
      cyc({nm, ".M"}, ILL, early_rdy, ~psr, mk(0,0,0,0,1,!ld,0,0,0, 4'd0, ins, 1'b0));
      for (int i = 1; i < wait_n; i++)
         cyc({nm, ".W"}, ILL, 1'b0, ~psr, mk(0,0,0,0,1,!ld,0,0,0, 4'd0, ins, 1'b0));
      cyc({nm, ".R"}, ILL, 1'b1, ~psr, mk(0,0,ld,0,1,!ld,0,0,ld, 4'd0, ins, 1'b0));
   endtask

   task automatic run_halt(input string nm, input logic [15:0] ins, input int n);
      fault_m = 1'b1;
      for (int i = 0; i < n; i++)
         cyc({nm, ".H"}, 16'h0152, 1'b1, ~psr, mk(0,0,0,0,0,0,0,0,0, 4'd0, ins, 1'b1));
   endtask

   task automatic do_reset(input string nm);
      $display("txn %s reset", nm);
      Rst_n = 1'b0;
      #1;
      check({nm, ".async"}, {2'b00, obs}, 32'd0);
      @(posedge Clk);
      #2;
      check({nm, ".hold"}, {2'b00, obs}, 32'd0);
      Rst_n    = 1'b1;
      prev_ir  = 16'h0000;
      prev_alu = 4'd0;
      psr      = 5'h00;
      fault_m  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      Rst_n = 1'b0;
      #1;
      check("reset.init", {2'b00, obs}, 32'd0);
      @(posedge Clk);
      #2;
      check("reset.init_hold", {2'b00, obs}, 32'd0);
      Rst_n = 1'b1;

      // ALU ops: name, instr, aluop, RegEn, FlagsEn, Imm_s, Signed, flags in EXEC
      run_alu("ADD",   16'h0152, 4'd0,  1, 1, 0, 0, 5'b01000);
      run_alu("ADDUI", 16'h63FF, 4'd0,  1, 1, 1, 0, 5'b00100);
      run_alu("CMPI",  16'hB305, 4'd2,  0, 1, 1, 1, 5'b00010);
      run_br ("BEQ_z1", 16'hC010, 1'b1);
      run_br ("BNE_z1", 16'hC110, 1'b0);
      run_br ("BHS_z1", 16'hCB20, 1'b1);
      run_alu("MUL",   16'h01E2, 4'd10, 1, 0, 0, 0, 5'b11111);
      run_br ("BEQ_kept", 16'hC010, 1'b1);
      run_alu("XORI",  16'h3207, 4'd5,  1, 0, 1, 1, 5'b11111);
      $display("txn NOP instr=0000");
      fetch_dec("NOP", 16'h0000, 4'd0);
      run_alu("LSH",   16'h8142, 4'd7,  1, 0, 0, 0, 5'b11111);
      run_alu("CMP",   16'h01B2, 4'd2,  0, 1, 0, 0, 5'b00000);
      run_br ("BEQ_z0", 16'hC010, 1'b0);
      run_br ("BUC",    16'hCE10, 1'b1);
      run_br ("BNV",    16'hCF10, 1'b0);
      run_br ("JUC",    16'h4EC7, 1'b1);
      run_br ("BLO",    16'hCA05, 1'b1);
      run_alu("SUB",   16'h0192, 4'd1,  1, 1, 0, 0, 5'b10001);
      run_br ("BCS",    16'hC210, 1'b1);
      run_br ("BGE",    16'hCD10, 1'b1);
      run_br ("BLT",    16'hCC10, 1'b0);
      run_br ("BCC",    16'hC310, 1'b0);
      run_br ("BGT",    16'hC610, 1'b1);

      run_mem("LOAD", 16'h4405, 1'b1, 3, 1'b1);
      run_mem("STOR", 16'h4445, 1'b0, 1, 1'b0);

      $display("txn LOAD_rst instr=4405");
      fetch_dec("LOAD_rst", 16'h4405, 4'd0);
      cyc("LOAD_rst.M", ILL, 1'b0, ~psr, mk(0,0,0,0,1,0,0,0,0, 4'd0, 16'h4405, 1'b0));
      cyc("LOAD_rst.W", ILL, 1'b0, ~psr, mk(0,0,0,0,1,0,0,0,0, 4'd0, 16'h4405, 1'b0));
      cyc("LOAD_rst.W", ILL, 1'b0, ~psr, mk(0,0,0,0,1,0,0,0,0, 4'd0, 16'h4405, 1'b0));
      do_reset("RST_midwait");
      run_alu("ADD_post", 16'h0152, 4'd0, 1, 1, 0, 0, 5'b00000);

      $display("txn LOAD_tmo instr=4405");
      fetch_dec("LOAD_tmo", 16'h4405, 4'd0);
      cyc("LOAD_tmo.M", ILL, 1'b0, ~psr, mk(0,0,0,0,1,0,0,0,0, 4'd0, 16'h4405, 1'b0));
      for (int i = 0; i < MEM_TMO; i++)
         cyc("LOAD_tmo.W", ILL, 1'b0, ~psr, mk(0,0,0,0,1,0,0,0,0, 4'd0, 16'h4405, 1'b0));
      run_halt("LOAD_tmo", 16'h4405, 3);
      do_reset("RST_tmo");

      $display("txn ILL_D instr=D000");
      fetch_dec("ILL_D", 16'hD000, 4'd0);
      run_halt("ILL_D", 16'hD000, 2);
      do_reset("RST_ill");

      $display("txn ILL_R instr=0140");
      fetch_dec("ILL_R", 16'h0140, 4'd0);
      run_halt("ILL_R", 16'h0140, 2);
      do_reset("RST_end");

      @(negedge Clk);
      #1;
      check("sb.drain", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
